div_pipe_unit: RTL
==================

# div_pipe_unit

Fully pipelined RV32M divide/remainder unit in the processor datapath's execute path, alongside the ALU. Accepts one DIV/DIVU/REM/REMU per cycle, carries the destination register tag through STAGES restoring-division stages and delivers a sign-corrected result toward memory/writeback. Exposes its per-stage valid vector and a register-hazard query, which the hazard unit uses to raise the divider-busy stall.

## Interface
- XLEN, 32: operand/result width.
- STAGES, 8: pipeline depth; must divide XLEN; each stage resolves XLEN/STAGES quotient bits.
- TAG_W, 5: destination tag width (rd index).

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  freeze every pipeline register (global pipeline stall).
- flush  in  1  kill all in-flight operations (branch flush).
- in_valid  in  1  operation present this cycle.
- in_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- in_a  in  XLEN  dividend (rs1 value).
- in_b  in  XLEN  divisor (rs2 value).
- in_rd  in  TAG_W  destination register.
- out_valid  out  1  result valid this cycle.
- out_rd  out  TAG_W  destination of out_result.
- out_result  out  XLEN  final quotient or remainder.
- valid_vec  out  STAGES  per-stage valid bits, bit 0 = youngest.
- busy  out  1  OR of valid_vec.
- query_rs1, query_rs2  in  TAG_W  source registers of the instruction in decode.
- hazard  out  1  a valid in-flight op (any stage, including final) has rd != 0 equal to query_rs1 or query_rs2.

## Operation
- Accept: in_valid && !stall && !flush. Stage-0 register captures |a|, |b| (signed ops only), op, rd, result-sign flags, divide-by-zero flag, overflow flag.
- Each stage performs XLEN/STAGES restoring steps: shift partial remainder left 1, bring in next dividend bit, subtract divisor if partial remainder >= divisor, shift quotient bit in. Partial remainder width XLEN+1.
- Final stage (registered output): quotient negated if sign(a) XOR sign(b) for DIV; remainder negated if sign(a) for REM.
- Special cases, decided at accept, override final result:
  - b == 0: quotient 0xFFFFFFFF (all ones), remainder = a (unmodified input).
  - DIV/REM with a == 0x80000000, b == 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- Unsigned ops never negate.
- hazard and busy are combinational from registered state; out_* driven from final-stage registers only.

## Timing
- Latency exactly STAGES cycles with no stall: accepted on edge N, out_valid high after edge N+STAGES for one cycle.
- Throughput 1 op/cycle; back-to-back ops emerge in order, one per cycle.
- stall high: all registers (data and valid) hold; out_valid holds its value; no accept. Each stall cycle adds one cycle of latency.
- flush high: all valid bits cleared at next edge, including the output stage; same-cycle in_valid dropped. flush overrides stall.
- Data registers of invalid stages are don't-care; they need not clear.
- Reset (any time, including mid-operation): valid_vec, out_valid, busy, hazard 0; out_rd 0; out_result 0. In-flight ops are lost; no output after reset release until a new accept.

## Configuration
- DIV_SIGNED_EN defined: full RV32M — DIV/REM take absolute values, sign fix-up and overflow case applied.
- Undefined: abs/negate logic and overflow detection not compiled; DIV treated as DIVU and REM as REMU. Divide-by-zero handling is unchanged.

## Structure
- Shared package: op encoding constants (OP_DIV, OP_DIVU, OP_REM, OP_REMU), XLEN and TAG_W defaults, stage-payload struct (partial remainder, quotient, |divisor|, rd, op, sign/special flags).
- One sub-module, div_pipe_stage: a single registered stage performing XLEN/STAGES restoring steps with stall hold; instantiated STAGES times via generate.

## Test plan
- DIV 100 / 7, rd=5 -> out_valid exactly 8 cycles later, out_result 14, out_rd 5; REMU same operands -> 2.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3); REM same -> 0xFFFFFFFF (-1); DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
- DIV 1234 / 0 -> 0xFFFFFFFF; REM 1234 / 0 -> 1234; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
- 8 back-to-back ops (a=k*10, b=3, k=1..8) -> 8 consecutive out_valid cycles with quotients 3,6,10,13,16,20,23,26 in order.
- Accept op, stall 3 cycles at stage 2 -> out_valid at cycle 11, valid_vec frozen during stall; hazard high for query_rs1 = its rd throughout, low for rd = 0.
- Two ops in flight, assert flush (optionally with stall and a new in_valid) -> valid_vec 0 next cycle, no out_valid; assert rst mid-flight -> all outputs 0 immediately.

Source files
------------

// File: rtl/div_pipe_unit_pkg.sv
// div_pipe_unit_pkg
// Shared definitions for the pipelined RV32M divide/remainder unit:
//   - op encoding constants (OP_DIV, OP_DIVU, OP_REM, OP_REMU)
//   - default XLEN / TAG_W
//   - the payload struct carried from stage to stage
// The payload struct is sized from DEF_XLEN / DEF_TAG_W, so the unit's
// XLEN / TAG_W parameters are expected to stay at these defaults.
package div_pipe_unit_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_TAG_W = 5;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    // quo starts out holding the (absolute) dividend. Each restoring step
    // shifts its MSB into rem and shifts a quotient bit in at the LSB, so
    // after XLEN steps quo holds the quotient and rem the remainder.
    typedef struct packed {
        logic [DEF_XLEN:0]    rem;    // partial remainder, one guard bit
        logic [DEF_XLEN-1:0]  quo;    // dividend bits in, quotient bits out
        logic [DEF_XLEN-1:0]  dvsr;   // |divisor|
        logic [DEF_TAG_W-1:0] rd;     // destination register
        logic [1:0]           op;     // operation
        logic                 neg_q;  // negate quotient at the end
        logic                 neg_r;  // negate remainder at the end
        logic                 dz;     // divide by zero
        logic                 ovf;    // signed overflow (MIN / -1)
    } div_payload_t;

    // REM/REMU select the remainder.
    function automatic logic is_rem_op(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_pipe_unit_if.sv
// div_pipe_unit_if
// Bundle of the divider's datapath-facing signals.
//   master: the issuing side (execute/decode/hazard logic, or a bench)
//   slave : the divider itself
// Handshake: there is no ready. An operation is taken on a rising edge
// when in_valid is high and stall and flush are both low; otherwise the
// offer is dropped and the issuer must present it again. out_valid marks
// a result for exactly one unstalled cycle; while stall is high it holds.
interface div_pipe_unit_if #(
    parameter int XLEN   = 32,
    parameter int TAG_W  = 5,
    parameter int STAGES = 8
);
    logic              stall;
    logic              flush;
    logic              in_valid;
    logic [1:0]        in_op;
    logic [XLEN-1:0]   in_a;
    logic [XLEN-1:0]   in_b;
    logic [TAG_W-1:0]  in_rd;
    logic              out_valid;
    logic [TAG_W-1:0]  out_rd;
    logic [XLEN-1:0]   out_result;
    logic [STAGES-1:0] valid_vec;
    logic              busy;
    logic [TAG_W-1:0]  query_rs1;
    logic [TAG_W-1:0]  query_rs2;
    logic              hazard;

    modport master (
        output stall, flush, in_valid, in_op, in_a, in_b, in_rd,
               query_rs1, query_rs2,
        input  out_valid, out_rd, out_result, valid_vec, busy, hazard
    );

    modport slave (
        input  stall, flush, in_valid, in_op, in_a, in_b, in_rd,
               query_rs1, query_rs2,
        output out_valid, out_rd, out_result, valid_vec, busy, hazard
    );
endinterface

// File: rtl/div_pipe_stage.sv
// div_pipe_stage
// One registered restoring-division stage: STEPS shift/compare/subtract
// steps on the incoming payload, then a register that holds under stall.
// Ports:
//   clk, rst        clock, async active-high reset (valid bit only)
//   stall, flush    hold everything / clear the valid bit
//   in_valid, in_pl incoming valid and payload
//   out_valid,out_pl registered valid and payload
module div_pipe_stage
    import div_pipe_unit_pkg::*;
#(
    parameter int STEPS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         flush,
    input  logic         in_valid,
    input  div_payload_t in_pl,
    output logic         out_valid,
    output div_payload_t out_pl
);

    div_payload_t nxt;

    always_comb begin
        nxt = in_pl;
        for (int i = 0; i < STEPS; i++) begin
            nxt.rem = {nxt.rem[DEF_XLEN-1:0], nxt.quo[DEF_XLEN-1]};
            nxt.quo = {nxt.quo[DEF_XLEN-2:0], 1'b0};
            if (nxt.rem >= {1'b0, nxt.dvsr}) begin
                nxt.rem    = nxt.rem - {1'b0, nxt.dvsr};
                nxt.quo[0] = 1'b1;
            end
        end
    end

    // flush wins over stall so a frozen pipeline can still be killed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (!stall) begin
            out_valid <= in_valid;
        end
    end

    // Payload of an invalid stage is never looked at, so no reset here.
    always_ff @(posedge clk) begin
        if (!stall) begin
            out_pl <= nxt;
        end
    end

endmodule

// File: rtl/div_pipe_unit.sv
// div_pipe_unit
// Fully pipelined DIV/DIVU/REM/REMU unit. One op per cycle, STAGES
// division stages of XLEN/STAGES steps each, followed by a registered
// sign-fixup output stage; latency is STAGES cycles.
// Ports:
//   clk, rst  clock, async active-high reset
//   bus       div_pipe_unit_if.slave: stall/flush, in_* operation,
//             out_* result, valid_vec/busy, query_rs1/2 -> hazard
// Build option: DIV_SIGNED_EN enables signed DIV/REM (abs values, sign
// fix-up, MIN/-1 overflow). Without it DIV behaves as DIVU and REM as
// REMU; divide-by-zero handling is the same in both builds.
module div_pipe_unit
    import div_pipe_unit_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int TAG_W  = DEF_TAG_W,
    parameter int STAGES = 8
) (
    input logic            clk,
    input logic            rst,
    div_pipe_unit_if.slave bus
);

    localparam int STEPS = XLEN / STAGES;

    logic         accept;
    div_payload_t in_pl;

    div_payload_t    pl_chain [STAGES+1];
    logic [STAGES:0] v_chain;

    logic [XLEN-1:0]  fin_q;
    logic [XLEN-1:0]  fin_r;
    logic [XLEN-1:0]  fin_res;

    logic             out_valid_q;
    logic [TAG_W-1:0] out_rd_q;
    logic [XLEN-1:0]  out_result_q;

    logic             hazard_c;

    assign accept = bus.in_valid && !bus.stall && !bus.flush;

    // Operand preparation. For b == 0 the dividend enters unmodified and
    // no sign fix-up is requested: restoring division by zero then yields
    // an all-ones quotient and remainder == a on its own.
    always_comb begin
        in_pl      = '0;
        in_pl.op   = bus.in_op;
        in_pl.rd   = bus.in_rd;
        in_pl.dz   = (bus.in_b == '0);
        in_pl.quo  = bus.in_a;
        in_pl.dvsr = bus.in_b;
`ifdef DIV_SIGNED_EN
        begin
            logic sgn_op;
            logic sa;
            logic sb;
            sgn_op = !bus.in_op[0];
            sa     = sgn_op && bus.in_a[XLEN-1];
            sb     = sgn_op && bus.in_b[XLEN-1];
            if (sa && !in_pl.dz) begin
                in_pl.quo = -bus.in_a;
            end
            if (sb) begin
                in_pl.dvsr = -bus.in_b;
            end
            in_pl.neg_q = (sa ^ sb) && !in_pl.dz;
            in_pl.neg_r = sa && !in_pl.dz;
            in_pl.ovf   = sgn_op && (bus.in_a == {1'b1, {(XLEN-1){1'b0}}})
                                 && (bus.in_b == '1);
        end
`endif
    end

    assign pl_chain[0] = in_pl;
    assign v_chain[0]  = accept;

    generate
        for (genvar g = 0; g < STAGES; g++) begin : g_stage
            div_pipe_stage #(
                .STEPS (STEPS)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .stall     (bus.stall),
                .flush     (bus.flush),
                .in_valid  (v_chain[g]),
                .in_pl     (pl_chain[g]),
                .out_valid (v_chain[g+1]),
                .out_pl    (pl_chain[g+1])
            );
        end
    endgenerate

    // Sign fix-up and special-case override on the last stage's payload.
    always_comb begin
        fin_q = pl_chain[STAGES].quo;
        fin_r = pl_chain[STAGES].rem[XLEN-1:0];
`ifdef DIV_SIGNED_EN
        if (pl_chain[STAGES].neg_q) begin
            fin_q = -pl_chain[STAGES].quo;
        end
        if (pl_chain[STAGES].neg_r) begin
            fin_r = -pl_chain[STAGES].rem[XLEN-1:0];
        end
        if (pl_chain[STAGES].ovf) begin
            fin_q = {1'b1, {(XLEN-1){1'b0}}};
            fin_r = '0;
        end
`endif
        if (pl_chain[STAGES].dz) begin
            fin_q = '1;
        end
        fin_res = is_rem_op(pl_chain[STAGES].op) ? fin_r : fin_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_rd_q     <= '0;
            out_result_q <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (!bus.stall) begin
            out_valid_q <= v_chain[STAGES];
            if (v_chain[STAGES]) begin
                out_rd_q     <= pl_chain[STAGES].rd;
                out_result_q <= fin_res;
            end
        end
    end

    function automatic logic rd_hit(input logic [TAG_W-1:0] rd,
                                    input logic [TAG_W-1:0] rs1,
                                    input logic [TAG_W-1:0] rs2);
        return (rd != '0) && ((rd == rs1) || (rd == rs2));
    endfunction

    // x0 is never a real dependency, so rd == 0 never raises a hazard.
    always_comb begin
        hazard_c = 1'b0;
        for (int i = 1; i <= STAGES; i++) begin
            if (v_chain[i] && rd_hit(pl_chain[i].rd, bus.query_rs1, bus.query_rs2)) begin
                hazard_c = 1'b1;
            end
        end
        if (out_valid_q && rd_hit(out_rd_q, bus.query_rs1, bus.query_rs2)) begin
            hazard_c = 1'b1;
        end
    end

    assign bus.valid_vec  = v_chain[STAGES:1];
    assign bus.busy       = |v_chain[STAGES:1];
    assign bus.hazard     = hazard_c;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_rd     = out_rd_q;
    assign bus.out_result = out_result_q;

endmodule
